// File: rtl/mmb_ram_slave.sv
// Burst-capable RAM responder for the MemoryMapped burst interface.
// Writes are taken beat-by-beat; a read burst is accepted once and streamed out in order.
module mmb_ram_slave #(
   parameter int DWIDTH  = 8,
   parameter int AWIDTH  = 32,
   parameter int BWIDTH  = 32,
   parameter int MAWIDTH = 10
) (
   input  logic              reset,
   input  logic              clk,
   input  logic [AWIDTH-1:0] s_addr,
   input  logic [BWIDTH-1:0] s_bcnt,
   input  logic              s_wreq,
   input  logic [DWIDTH-1:0] s_wdat,
   input  logic              s_rreq,
   output logic [DWIDTH-1:0] s_rdat,
   output logic              s_rval,
   output logic              s_busy,
   output logic              proto_err
);

   localparam int DEPTH = 2 ** MAWIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [MAWIDTH-1:0]  base_r;
   logic [MAWIDTH-1:0]  ptr_r;
   logic [BWIDTH-1:0]   rem_r;
   logic [DWIDTH-1:0]   mem_r [DEPTH];
   logic [DWIDTH-1:0]   rdat_r;
   logic                rval_r;
   logic                perr_r;

   logic [MAWIDTH-1:0]  addr_idx_s;
   logic [MAWIDTH-1:0]  burst_idx_s;
   logic [MAWIDTH-1:0]  wr_idx_s;
   logic [MAWIDTH-1:0]  rd_idx_s;
   logic [BWIDTH-1:0]   bcnt_m1_s;
   logic                single_s;
   logic                last_s;
   logic                wr_en_s;
   logic                rd_en_s;
   logic                load_s;
   logic                advance_s;
   logic                err_s;
   logic                unused_addr_s;

   assign addr_idx_s    = s_addr[MAWIDTH-1:0];
   assign burst_idx_s   = base_r + ptr_r;
   assign bcnt_m1_s     = s_bcnt - BWIDTH'(1'b1);
   assign single_s      = (bcnt_m1_s == {BWIDTH{1'b0}});
   assign last_s        = (rem_r == BWIDTH'(1'b1));
   assign unused_addr_s = ^s_addr;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (s_wreq) begin
               state_nxt_s = single_s ? ST_IDLE : ST_WRITE;
            end else if (s_rreq) begin
               state_nxt_s = single_s ? ST_IDLE : ST_READ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (s_wreq && last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WRITE;
            end
         end
         ST_READ: begin
            state_nxt_s = last_s ? ST_IDLE : ST_READ;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // handshake and datapath controls; inside a write burst s_busy only stalls reads,
   // so write beats keep flowing while a read request waits
   always_comb begin
      s_busy    = 1'b0;
      wr_en_s   = 1'b0;
      rd_en_s   = 1'b0;
      load_s    = 1'b0;
      advance_s = 1'b0;
      err_s     = 1'b0;
      wr_idx_s  = addr_idx_s;
      rd_idx_s  = addr_idx_s;
      case (state_r)
         ST_IDLE: begin
            if (s_wreq) begin
               wr_en_s = 1'b1;
               load_s  = 1'b1;
               err_s   = s_rreq;
            end else if (s_rreq) begin
               rd_en_s = 1'b1;
               load_s  = 1'b1;
            end else begin
               load_s  = 1'b0;
            end
         end
         ST_WRITE: begin
            s_busy   = s_rreq;
            wr_idx_s = burst_idx_s;
            if (s_wreq) begin
               wr_en_s   = 1'b1;
               advance_s = 1'b1;
            end else begin
               advance_s = 1'b0;
            end
         end
         ST_READ: begin
            s_busy    = 1'b1;
            rd_en_s   = 1'b1;
            rd_idx_s  = burst_idx_s;
            advance_s = 1'b1;
         end
         default: begin
            s_busy = 1'b0;
         end
      endcase
   end

   // burst pointer/counter and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_r <= {MAWIDTH{1'b0}};
         ptr_r  <= {MAWIDTH{1'b0}};
         rem_r  <= {BWIDTH{1'b0}};
         rdat_r <= {DWIDTH{1'b0}};
         rval_r <= 1'b0;
         perr_r <= 1'b0;
      end else begin
         if (load_s) begin
            base_r <= addr_idx_s;
            ptr_r  <= MAWIDTH'(1'b1);
            rem_r  <= bcnt_m1_s;
         end else if (advance_s) begin
            ptr_r  <= ptr_r + MAWIDTH'(1'b1);
            rem_r  <= rem_r - BWIDTH'(1'b1);
         end else begin
            ptr_r  <= ptr_r;
         end
         if (rd_en_s) begin
            rdat_r <= mem_r[rd_idx_s];
         end else begin
            rdat_r <= rdat_r;
         end
         rval_r <= rd_en_s;
         perr_r <= err_s;
      end
   end

   // RAM array, contents intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= s_wdat;
      end
   end

   assign s_rdat    = rdat_r;
   assign s_rval    = rval_r;
   assign proto_err = perr_r;

endmodule

// File: tb/tb_mmb_ram_slave.sv
// Randomised and directed bench for mmb_ram_slave against a queue-based memory model.
module tb_mmb_ram_slave;

   localparam int DW  = 8;
   localparam int AW  = 32;
   localparam int BW  = 4;
   localparam int MAW = 4;
   localparam int DEP = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] s_addr;
   logic [BW-1:0] s_bcnt;
   logic          s_wreq;
   logic [DW-1:0] s_wdat;
   logic          s_rreq;
   logic [DW-1:0] s_rdat;
   logic          s_rval;
   logic          s_busy;
   logic          proto_err;

   mmb_ram_slave #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW), .MAWIDTH(MAW)) dut (
      .reset(reset), .clk(clk), .s_addr(s_addr), .s_bcnt(s_bcnt), .s_wreq(s_wreq),
      .s_wdat(s_wdat), .s_rreq(s_rreq), .s_rdat(s_rdat), .s_rval(s_rval),
      .s_busy(s_busy), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   int busy_hi = 0;
   int perr_seen = 0;
   logic [7:0] got_q[$];

   // reference model: memory image plus words still owed to the reader
   logic [7:0] mem_m [DEP];
   logic [7:0] rd_pend[$];
   int         wr_left = 0;
   int         wbase = 0;
   int         wptr = 0;
   logic       exp_valid = 1'b0;
   logic [7:0] exp_data = 8'h00;
   logic       exp_perr = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic model_reset();
      rd_pend.delete();
      wr_left   = 0;
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_perr  = 1'b0;
   endtask

   task automatic model_edge(input logic w, input logic r, input logic [7:0] d,
                             input logic [31:0] a, input logic [3:0] b);
      int n;
      int ai;
      exp_perr  = 1'b0;
      exp_valid = 1'b0;
      ai = int'(a[3:0]);
      n  = (b == 4'd0) ? 16 : int'(b);
      if (rd_pend.size() > 0) begin
         exp_data  = rd_pend.pop_front();
         exp_valid = 1'b1;
      end else if (wr_left > 0) begin
         if (w) begin
            mem_m[(wbase + wptr) % DEP] = d;
            wptr++;
            wr_left--;
         end
      end else if (w) begin
         mem_m[ai] = d;
         wbase     = ai;
         wptr      = 1;
         wr_left   = n - 1;
         exp_perr  = r;
      end else if (r) begin
         for (int i = 0; i < n; i++) rd_pend.push_back(mem_m[(ai + i) % DEP]);
         exp_data  = rd_pend.pop_front();
         exp_valid = 1'b1;
      end
   endtask

   // one clock: drive at negedge, check s_busy, advance model, check registered outputs
   task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                      input logic [31:0] a, input logic [3:0] b);
      logic exp_busy;
      s_wreq = w; s_rreq = r; s_wdat = d; s_addr = a; s_bcnt = b;
      #1;
      exp_busy = (rd_pend.size() > 0) || (wr_left > 0 && r);
      chk("busy", 32'(s_busy), 32'(exp_busy));
      if (s_busy) busy_hi++;
      model_edge(w, r, d, a, b);
      @(negedge clk);
      chk("rval", 32'(s_rval), 32'(exp_valid));
      chk("rdat", 32'(s_rdat), 32'(exp_data));
      chk("proto_err", 32'(proto_err), 32'(exp_perr));
      if (s_rval) got_q.push_back(s_rdat);
      if (proto_err) perr_seen++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 32'h0, 4'd0);
   endtask

   task automatic clear_obs();
      got_q.delete();
      busy_hi = 0;
      perr_seen = 0;
   endtask

   initial begin
      reset = 1'b0; s_wreq = 1'b0; s_rreq = 1'b0; s_wdat = 8'h00;
      s_addr = 32'h0; s_bcnt = 4'd0;
      repeat (2) @(negedge clk);
      chk("rst_rval", 32'(s_rval), 32'h0);
      chk("rst_rdat", 32'(s_rdat), 32'h0);
      chk("rst_perr", 32'(proto_err), 32'h0);
      chk("rst_busy", 32'(s_busy), 32'h0);
      reset = 1'b1;
      model_reset();

      // fill the whole RAM with a bcnt=0 (16-beat) burst; later addr/bcnt are ignored
      cyc(1'b1, 1'b0, 8'h50, 32'h0, 4'd0);
      for (int i = 1; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i), $urandom, 4'($urandom));
      chk("fill_done_busy", 32'(wr_left), 32'd0);

      // write with an idle gap, then read it back
      cyc(1'b1, 1'b0, 8'hA0, 32'h10, 4'd4);
      cyc(1'b1, 1'b0, 8'hA1, 32'h0, 4'd0);
      idle(1);
      cyc(1'b1, 1'b0, 8'hA2, 32'h0, 4'd0);
      cyc(1'b1, 1'b0, 8'hA3, 32'h0, 4'd0);
      clear_obs();
      cyc(1'b0, 1'b1, 8'h00, 32'h10, 4'd4);
      idle(4);
      chk("t2_count", 32'(got_q.size()), 32'd4);
      chk("t2_w0", 32'(got_q[0]), 32'hA0);
      chk("t2_w3", 32'(got_q[3]), 32'hA3);
      chk("t2_busy_cycles", 32'(busy_hi), 32'd3);

      // wrap inside the 16-word RAM
      cyc(1'b1, 1'b0, 8'h01, 32'hE, 4'd4);
      cyc(1'b1, 1'b0, 8'h02, 32'h0, 4'd0);
      cyc(1'b1, 1'b0, 8'h03, 32'h0, 4'd0);
      cyc(1'b1, 1'b0, 8'h04, 32'h0, 4'd0);
      clear_obs();
      cyc(1'b0, 1'b1, 8'h00, 32'h0, 4'd2);
      idle(2);
      cyc(1'b0, 1'b1, 8'h00, 32'hE, 4'd2);
      idle(2);
      chk("t3_count", 32'(got_q.size()), 32'd4);
      chk("t3_idx0", 32'(got_q[0]), 32'h03);
      chk("t3_idx1", 32'(got_q[1]), 32'h04);
      chk("t3_idx14", 32'(got_q[2]), 32'h01);
      chk("t3_idx15", 32'(got_q[3]), 32'h02);

      // single-word reads back to back
      clear_obs();
      cyc(1'b0, 1'b1, 8'h00, 32'h5, 4'd1);
      cyc(1'b0, 1'b1, 8'h00, 32'h6, 4'd1);
      cyc(1'b0, 1'b1, 8'h00, 32'h7, 4'd1);
      idle(1);
      chk("t4_busy_cycles", 32'(busy_hi), 32'd0);
      chk("t4_count", 32'(got_q.size()), 32'd3);
      chk("t4_w5", 32'(got_q[0]), 32'h55);
      chk("t4_w7", 32'(got_q[2]), 32'h57);

      // read request held during a write burst
      clear_obs();
      cyc(1'b1, 1'b0, 8'h81, 32'h8, 4'd3);
      cyc(1'b1, 1'b1, 8'h82, 32'h0, 4'd0);
      cyc(1'b1, 1'b1, 8'h83, 32'h0, 4'd0);
      cyc(1'b0, 1'b1, 8'h00, 32'h9, 4'd1);
      idle(1);
      chk("t5_busy_cycles", 32'(busy_hi), 32'd2);
      chk("t5_perr", 32'(perr_seen), 32'd0);
      chk("t5_data", 32'(got_q[0]), 32'h82);

      // simultaneous write and read in IDLE
      clear_obs();
      cyc(1'b1, 1'b1, 8'hC6, 32'h20, 4'd1);
      idle(1);
      chk("t6_perr", 32'(perr_seen), 32'd1);
      chk("t6_no_rval", 32'(got_q.size()), 32'd0);
      cyc(1'b0, 1'b1, 8'h00, 32'h20, 4'd1);
      idle(1);
      chk("t6_data", 32'(got_q[0]), 32'hC6);

      // asynchronous reset in the middle of a read burst
      cyc(1'b0, 1'b1, 8'h00, 32'h0, 4'd8);
      idle(2);
      #2 reset = 1'b0;
      #1;
      chk("t1_rval", 32'(s_rval), 32'h0);
      chk("t1_busy", 32'(s_busy), 32'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_obs();
      idle(4);
      chk("t1_no_rval", 32'(got_q.size()), 32'd0);

      // randomised traffic
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0), 8'($urandom),
             $urandom, 4'($urandom_range(0, 15)));
      end
      idle(20);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
